// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter -- iterative AES-128 decryption core, one round per clock.
//
// The master key is first expanded forward to K10 (KEXP, 10 cycles). The
// inverse rounds then walk the schedule back from K10 to K0, one key per
// round. Latency from the accepting edge to Valid is 21 cycles.
//
// Optional feature (compile-time macro AES_DEC_KEY_CACHE_EN):
//   Caches the last completed master key together with its K10. A new block
//   whose key matches the cache skips KEXP and completes in 11 cycles.
//
// Ports:
//   CLK    in   rising-edge clock
//   RST    in   asynchronous active-low reset
//   En     in   start request, sampled only while idle
//   CT     in   ciphertext, captured on the accepting edge
//   M_Key  in   master key, captured on the accepting edge
//   PT     out  plaintext, registered, holds until the next completion
//   Valid  out  one-cycle pulse when PT is updated
//   Busy   out  high from acceptance through the completing edge
module aes_decrypt_iter #(
  parameter int BLOCK_LENGTH = 128,
  parameter int KEY_LENGTH   = 128
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    En,
  input  logic [BLOCK_LENGTH-1:0] CT,
  input  logic [KEY_LENGTH-1:0]   M_Key,
  output logic [BLOCK_LENGTH-1:0] PT,
  output logic                    Valid,
  output logic                    Busy
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [2:0] {IDLE, KEXP, WHITEN, ROUND, FINAL} fsm_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  // Round constant for round index 1..10; other indices never use it.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant (9, 11, 13, 14 for InvMixColumns).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h000000};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one forward step: recover the later words first, since w0 needs
  // the previous key's w3.
  function automatic logic [127:0] key_rev(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  // Byte (r,c) sits at bits [127-8*(4c+r) -: 8]; row r rotates right by r.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 4'd14) ^ gf_mul(a1, 4'd11) ^ gf_mul(a2, 4'd13) ^ gf_mul(a3, 4'd9);
      o[119-32*c -: 8] = gf_mul(a0, 4'd9)  ^ gf_mul(a1, 4'd14) ^ gf_mul(a2, 4'd11) ^ gf_mul(a3, 4'd13);
      o[111-32*c -: 8] = gf_mul(a0, 4'd13) ^ gf_mul(a1, 4'd9)  ^ gf_mul(a2, 4'd14) ^ gf_mul(a3, 4'd11);
      o[103-32*c -: 8] = gf_mul(a0, 4'd11) ^ gf_mul(a1, 4'd13) ^ gf_mul(a2, 4'd9)  ^ gf_mul(a3, 4'd14);
    end
    return o;
  endfunction

  fsm_e                    fsm_q, fsm_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [BLOCK_LENGTH-1:0] blk_q, blk_d;
  logic [KEY_LENGTH-1:0]   key_q, key_d;
  logic [BLOCK_LENGTH-1:0] pt_q, pt_d;
  logic                    valid_q, valid_d;

  logic [127:0] inv_ss;
  logic [127:0] key_next_fwd;
  logic [127:0] key_next_rev;

  assign inv_ss       = inv_shift_sub(blk_q);
  assign key_next_fwd = key_fwd(key_q, rcon(cnt_q));
  // The counter holds the index of the key currently in key_q (10 in WHITEN).
  assign key_next_rev = key_rev(key_q, rcon(cnt_q));

`ifdef AES_DEC_KEY_CACHE_EN
  logic [KEY_LENGTH-1:0] mkey_q, mkey_d;
  logic [KEY_LENGTH-1:0] k10_q, k10_d;
  logic [KEY_LENGTH-1:0] ckey_q, ckey_d;
  logic [KEY_LENGTH-1:0] ck10_q, ck10_d;
  logic                  cvld_q, cvld_d;
  logic                  cache_hit;

  assign cache_hit = cvld_q && (M_Key == ckey_q);

  // The cache is only committed at FINAL, so an aborted block never
  // leaves a half-written entry behind.
  always_comb begin
    mkey_d = mkey_q;
    k10_d  = k10_q;
    ckey_d = ckey_q;
    ck10_d = ck10_q;
    cvld_d = cvld_q;
    if (fsm_q == IDLE && En) mkey_d = M_Key;
    if (fsm_q == WHITEN)     k10_d  = key_q;
    if (fsm_q == FINAL) begin
      ckey_d = mkey_q;
      ck10_d = k10_q;
      cvld_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mkey_q <= '0;
      k10_q  <= '0;
      ckey_q <= '0;
      ck10_q <= '0;
      cvld_q <= 1'b0;
    end else begin
      mkey_q <= mkey_d;
      k10_q  <= k10_d;
      ckey_q <= ckey_d;
      ck10_q <= ck10_d;
      cvld_q <= cvld_d;
    end
  end
`endif

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    key_d   = key_q;
    pt_d    = pt_q;
    valid_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (En) begin
          blk_d = CT;
          key_d = M_Key;
          cnt_d = 4'd1;
          fsm_d = KEXP;
`ifdef AES_DEC_KEY_CACHE_EN
          if (cache_hit) begin
            key_d = ck10_q;
            cnt_d = 4'd10;
            fsm_d = WHITEN;
          end
`endif
        end
      end
      KEXP: begin
        key_d = key_next_fwd;
        // Counter stays at 10 so WHITEN reverses with Rcon[10].
        if (cnt_q == 4'd10) fsm_d = WHITEN;
        else                cnt_d = cnt_q + 4'd1;
      end
      WHITEN: begin
        blk_d = blk_q ^ key_q;
        key_d = key_next_rev;
        cnt_d = 4'd9;
        fsm_d = ROUND;
      end
      ROUND: begin
        blk_d = inv_mix(inv_ss ^ key_q);
        key_d = key_next_rev;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) fsm_d = FINAL;
      end
      FINAL: begin
        pt_d    = inv_ss ^ key_q;
        valid_d = 1'b1;
        fsm_d   = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      valid_q <= valid_d;
    end
  end

  assign PT    = pt_q;
  assign Valid = valid_q;
  assign Busy  = (fsm_q != IDLE);

endmodule
